// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected execute stage: state encoding,
// rounding/saturation helpers and a width helper.
package fc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic int unsigned fc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Index width for an array of v entries; never narrower than one bit.
  function automatic int unsigned fc_idx_w(input int unsigned v);
    return (fc_clog2(v) == 0) ? 1 : fc_clog2(v);
  endfunction

  function automatic longint fc_sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint fc_sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic longint fc_round_half(input int unsigned shift);
    return 64'sd1 <<< (shift - 1);
  endfunction

endpackage

// File: rtl/fc_post_unit.sv
// Combinational neuron finaliser: bias add, round-half-up shift, saturate,
// optional ReLU. Shared serially across all neurons.
module fc_post_unit
  import fc_pkg::*;
#(
  parameter int unsigned SUM_W      = 27,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BIAS_SHIFT = 0,
  parameter int unsigned OUT_SHIFT  = 7
) (
  input  logic signed [SUM_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     relu_en,
  output logic signed [DATA_W-1:0] res_c,
  output logic                     sat_c
);

  // Two headroom bits: one for the bias add, one so the rounding add cannot wrap.
  localparam int unsigned S_W = SUM_W + 2;
  localparam logic signed [S_W-1:0] RND_V = S_W'(fc_round_half(OUT_SHIFT));
  localparam logic signed [S_W-1:0] MAX_V = S_W'(fc_sat_max(DATA_W));
  localparam logic signed [S_W-1:0] MIN_V = S_W'(fc_sat_min(DATA_W));

  logic signed [S_W-1:0] sum;
  logic signed [S_W-1:0] rnd;
  logic signed [S_W-1:0] clip;

  always_comb begin
    sum   = S_W'(acc) + (S_W'(bias) <<< BIAS_SHIFT);
    rnd   = (sum + RND_V) >>> OUT_SHIFT;
    clip  = rnd;
    sat_c = 1'b0;
    if (rnd > MAX_V) begin
      clip  = MAX_V;
      sat_c = 1'b1;
    end else if (rnd < MIN_V) begin
      clip  = MIN_V;
      sat_c = 1'b1;
    end
    res_c = DATA_W'(clip);
    if (relu_en && (clip < 0)) res_c = '0;
  end

endmodule

// File: rtl/fc_exec_seq.sv
// Fully-connected execute stage: parallel per-neuron accumulation over input
// chunks, then serial finalisation into a registered-read result file.
module fc_exec_seq
  import fc_pkg::*;
#(
  parameter int unsigned N_OUT      = 84,
  parameter int unsigned ACC_W      = 23,
  parameter int unsigned GUARD_W    = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BIAS_SHIFT = 0,
  parameter int unsigned OUT_SHIFT  = 7,
  parameter int unsigned AW         = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   acc_vld,
  input  logic                   acc_first,
  input  logic                   acc_last,
  input  logic [N_OUT*ACC_W-1:0] acc_in,
  output logic                   in_rdy,
  input  logic                   relu_en,
  input  logic                   b_we,
  input  logic [AW-1:0]          b_waddr,
  input  logic [DATA_W-1:0]      b_wdata,
  input  logic [AW-1:0]          rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   res_vld,
  output logic                   sat_flag
);

  localparam int unsigned SUM_W = ACC_W + GUARD_W;
  localparam int unsigned IW    = fc_idx_w(N_OUT);
  localparam int unsigned AW1   = AW + 1;
  localparam logic [AW:0]   N_LIM    = AW1'(N_OUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);

  logic signed [SUM_W-1:0]  acc_q  [N_OUT];
  logic signed [DATA_W-1:0] bias_q [N_OUT];
  logic [DATA_W-1:0]        res_q  [N_OUT];

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] rd_addr_q;

  logic                     accept_c;
  logic                     fin_c;
  logic                     fin_last_c;
  logic signed [DATA_W-1:0] post_res_c;
  logic                     post_sat_c;

  assign accept_c   = acc_vld & in_rdy;
  assign fin_c      = (state_q == ST_FIN);
  assign fin_last_c = fin_c && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACC: if (accept_c) state_d = acc_last ? ST_FIN : ST_ACC;
      ST_FIN:          if (idx_q == LAST_IDX) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Control outputs and the finalisation index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_rdy   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_vld  <= 1'b0;
      sat_flag <= 1'b0;
      idx_q    <= '0;
    end else begin
      in_rdy <= (state_d != ST_FIN);
      busy   <= (state_d == ST_FIN);
      done   <= fin_last_c;
      if (accept_c && acc_first) res_vld <= 1'b0;
      else if (fin_last_c)       res_vld <= 1'b1;
      if (accept_c && acc_first)  sat_flag <= 1'b0;
      else if (fin_c && post_sat_c) sat_flag <= 1'b1;
      idx_q <= (fin_c && !fin_last_c) ? idx_q + IW'(1) : '0;
    end
  end

  // Per-neuron accumulators; wrap silently at SUM_W bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_OUT); i++) acc_q[i] <= '0;
    end else if (accept_c) begin
      for (int i = 0; i < int'(N_OUT); i++) begin
        if (acc_first) acc_q[i] <= SUM_W'($signed(acc_in[ACC_W*i +: ACC_W]));
        else           acc_q[i] <= acc_q[i] + SUM_W'($signed(acc_in[ACC_W*i +: ACC_W]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_OUT); i++) bias_q[i] <= '0;
    end else if (b_we && (AW1'(b_waddr) < N_LIM)) begin
      bias_q[b_waddr[IW-1:0]] <= b_wdata;
    end
  end

  fc_post_unit #(
    .SUM_W      (SUM_W),
    .DATA_W     (DATA_W),
    .BIAS_SHIFT (BIAS_SHIFT),
    .OUT_SHIFT  (OUT_SHIFT)
  ) u_post (
    .acc     (acc_q[idx_q]),
    .bias    (bias_q[idx_q]),
    .relu_en (relu_en),
    .res_c   (post_res_c),
    .sat_c   (post_sat_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_OUT); i++) res_q[i] <= '0;
    end else if (fin_c) begin
      res_q[idx_q] <= post_res_c;
    end
  end

  // Two-stage read: address register, then data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      rd_data   <= '0;
    end else begin
      rd_addr_q <= rd_addr;
      rd_data   <= (AW1'(rd_addr_q) < N_LIM) ? res_q[rd_addr_q[IW-1:0]] : '0;
    end
  end

endmodule
